// File: rtl/cpu_mem_responder_pkg.sv
// Shared CPU-side definitions for the memory responder: FSM states, NOP encoding
// and address range helpers.
package cpu_mem_responder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_e;

    // Word index of a byte address lies beyond a memory of the given depth.
    function automatic logic word_oor(input logic [XLEN-1:0] addr, input int unsigned words);
        return (addr >> 2) >= XLEN'(words);
    endfunction

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_word_ram.sv
// Word-wide RAM with asynchronous read and synchronous write; contents are not reset.
module word_ram #(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata_c
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Instruction/data memory responder for a CPU: loader fills imem while the CPU is
// held in reset, then serves fetches and loads/stores with fault trapping.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC,
    output logic [31:0]      Inst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      data_out,
    input  logic             MemWE,
    output logic [31:0]      data_in,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             cpu_reset,
    output logic             misalign_err,
    output logic             range_err,
    output logic [CNT_W-1:0] store_count
);

    localparam int unsigned IMEM_AW = $clog2(IMEM_WORDS);
    localparam int unsigned DMEM_AW = $clog2(DMEM_WORDS);

    state_e             state_q, state_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               ld_ready_q, ld_ready_d;
    logic               misalign_q, misalign_d;
    logic               range_q, range_d;
    logic [CNT_W-1:0]   store_count_q, store_count_d;

    logic               imem_we, dmem_we;
    logic [31:0]        imem_rdata, dmem_rdata;

    logic               ld_mis, ld_oor;
    logic               pc_mis, pc_oor;
    logic               st_mis, st_oor;
    logic               dm_oor;

    assign ld_mis = misaligned(ld_addr);
    assign ld_oor = word_oor(ld_addr, IMEM_WORDS);
    assign pc_mis = misaligned(PC);
    assign pc_oor = word_oor(PC, IMEM_WORDS);
    assign dm_oor = word_oor(mem_addr, DMEM_WORDS);
    assign st_mis = MemWE && misaligned(mem_addr);
    assign st_oor = MemWE && dm_oor;

    // Next-state, fault capture and memory write enables
    always_comb begin
        state_d       = state_q;
        misalign_d    = misalign_q;
        range_d       = range_q;
        store_count_d = store_count_q;
        imem_we       = 1'b0;
        dmem_we       = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (ld_valid && ld_ready_q) begin
                    if (ld_mis) misalign_d = 1'b1;
                    if (ld_oor) range_d    = 1'b1;
                    imem_we = !ld_mis && !ld_oor;
                    if (ld_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RUN;
            end
            RUN: begin
                if (pc_mis || st_mis) misalign_d = 1'b1;
                if (pc_oor || st_oor) range_d    = 1'b1;
                if (pc_mis || pc_oor || st_mis || st_oor) begin
                    state_d = FAULT;
                end else if (MemWE) begin
                    dmem_we = 1'b1;
                    if (store_count_q != {CNT_W{1'b1}}) begin
                        store_count_d = store_count_q + CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // A reset edge aborts any write in flight
        if (reset) begin
            imem_we = 1'b0;
            dmem_we = 1'b0;
        end

        cpu_reset_d = (state_d != RUN);
        ld_ready_d  = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= LOAD;
            cpu_reset_q   <= 1'b1;
            ld_ready_q    <= 1'b1;
            misalign_q    <= 1'b0;
            range_q       <= 1'b0;
            store_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cpu_reset_q   <= cpu_reset_d;
            ld_ready_q    <= ld_ready_d;
            misalign_q    <= misalign_d;
            range_q       <= range_d;
            store_count_q <= store_count_d;
        end
    end

    word_ram #(.DEPTH(IMEM_WORDS)) u_imem (
        .clk     (clk),
        .we      (imem_we),
        .waddr   (ld_addr[IMEM_AW+1:2]),
        .wdata   (ld_data),
        .raddr   (PC[IMEM_AW+1:2]),
        .rdata_c (imem_rdata)
    );

    word_ram #(.DEPTH(DMEM_WORDS)) u_dmem (
        .clk     (clk),
        .we      (dmem_we),
        .waddr   (mem_addr[DMEM_AW+1:2]),
        .wdata   (data_out),
        .raddr   (mem_addr[DMEM_AW+1:2]),
        .rdata_c (dmem_rdata)
    );

    assign Inst         = (state_q == RUN && !pc_oor) ? imem_rdata : NOP_INST;
    assign data_in      = dm_oor ? 32'h0 : dmem_rdata;
    assign cpu_reset    = cpu_reset_q;
    assign ld_ready     = ld_ready_q;
    assign misalign_err = misalign_q;
    assign range_err    = range_q;
    assign store_count  = store_count_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with a cycle-level behavioural model and
// per-cycle output comparison.
module tb_cpu_mem_responder;

    localparam int unsigned IW  = 256;
    localparam int unsigned DW  = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_LOAD  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC, mem_addr, data_out, ld_addr, ld_data;
    logic        MemWE, ld_valid, ld_last;
    logic [31:0] Inst, data_in;
    logic        ld_ready, cpu_reset, misalign_err, range_err;
    logic [15:0] store_count;

    int checks   = 0;
    int failures = 0;

    cpu_mem_responder #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .PC           (PC),
        .Inst         (Inst),
        .mem_addr     (mem_addr),
        .data_out     (data_out),
        .MemWE        (MemWE),
        .data_in      (data_in),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .cpu_reset    (cpu_reset),
        .misalign_err (misalign_err),
        .range_err    (range_err),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: memories as plain arrays with "known" tags
    bit [31:0] imem_m [IW];
    bit [31:0] dmem_m [DW];
    bit        ik [IW];
    bit        dk [DW];
    int        mode  = M_LOAD;
    bit        m_mis = 1'b0;
    bit        m_rng = 1'b0;
    int        m_cnt = 0;
    bit        mvalid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mode = M_LOAD; m_mis = 1'b0; m_rng = 1'b0; m_cnt = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            if (mode == M_LOAD) begin
                if (ld_valid) begin
                    if (ld_addr % 4 != 0) m_mis = 1'b1;
                    if (ld_addr / 4 >= IW) m_rng = 1'b1;
                    if (ld_addr % 4 == 0 && ld_addr / 4 < IW) begin
                        imem_m[ld_addr / 4] = ld_data;
                        ik[ld_addr / 4] = 1'b1;
                    end
                    if (ld_last) mode = M_DRAIN;
                end
            end else if (mode == M_DRAIN) begin
                mode = M_RUN;
            end else if (mode == M_RUN) begin
                bit bad_align, bad_range;
                bad_align = (PC % 4 != 0) || (MemWE && mem_addr % 4 != 0);
                bad_range = (PC / 4 >= IW) || (MemWE && mem_addr / 4 >= DW);
                if (bad_align) m_mis = 1'b1;
                if (bad_range) m_rng = 1'b1;
                if (bad_align || bad_range) begin
                    mode = M_FAULT;
                end else if (MemWE) begin
                    dmem_m[mem_addr / 4] = data_out;
                    dk[mem_addr / 4] = 1'b1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("cpu_reset", 32'(cpu_reset), 32'(mode != M_RUN));
            chk("ld_ready", 32'(ld_ready), 32'(mode == M_LOAD));
            chk("misalign_err", 32'(misalign_err), 32'(m_mis));
            chk("range_err", 32'(range_err), 32'(m_rng));
            chk("store_count", 32'(store_count), 32'(m_cnt));
            if (mode != M_RUN) chk("Inst_nop", Inst, NOP);
            else if (PC / 4 < IW && ik[PC / 4]) chk("Inst", Inst, imem_m[PC / 4]);
            if (mem_addr / 4 >= DW) chk("data_in_oor", data_in, 32'h0);
            else if (dk[mem_addr / 4]) chk("data_in", data_in, dmem_m[mem_addr / 4]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; PC = '0; mem_addr = '0; data_out = '0; MemWE = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        #1;
        cyc(); cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_flags", {30'd0, misalign_err, range_err}, 32'd0);
        chk("rst_count", 32'(store_count), 32'd0);
        chk("rst_inst", Inst, 32'h0000_0013);
        cyc();

        // Loader: good beat, misaligned beat, out-of-range beat
        beat(32'h0, 32'h1111_1111, 1'b0);
        beat(32'h2, 32'hBAD0_BAD0, 1'b0);
        @(negedge clk);
        chk("ldmis_flag", 32'(misalign_err), 32'd1);
        chk("ldmis_range", 32'(range_err), 32'd0);
        chk("ldmis_ready", 32'(ld_ready), 32'd1);
        cyc();
        beat(32'(4 * IW), 32'hBAD1_BAD1, 1'b0);
        @(negedge clk);
        chk("ldoor_flag", 32'(range_err), 32'd1);
        cyc();

        // Reset in the same cycle as a loader beat: no write
        reset = 1'b1; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h9999_9999;
        cyc();
        reset = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        chk("rstld_flags", {30'd0, misalign_err, range_err}, 32'd0);
        cyc();

        // Burst completion, DRAIN timing
        beat(32'h4, 32'h1234_5678, 1'b0);
        beat(32'h8, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);
        chk("drain_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("drain_ready", 32'(ld_ready), 32'd0);
        cyc();
        PC = 32'h4;
        @(negedge clk);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_inst4", Inst, 32'h1234_5678);
        cyc();
        PC = 32'h0;
        @(negedge clk);
        chk("run_inst0", Inst, 32'h1111_1111);
        cyc();

        // Stores and out-of-range / misaligned loads
        MemWE = 1'b1; mem_addr = 32'h10; data_out = 32'h0102_0304;
        cyc();
        mem_addr = 32'h14; data_out = 32'h0A0B_0C0D;
        cyc();
        MemWE = 1'b0; mem_addr = 32'h11;
        @(negedge clk);
        chk("misld_data", data_in, 32'h0102_0304);
        chk("st_count2", 32'(store_count), 32'd2);
        cyc();
        mem_addr = 32'(4 * DW);
        @(negedge clk);
        chk("oorld_data", data_in, 32'h0);
        chk("oorld_nofault", 32'(cpu_reset), 32'd0);
        cyc();

        // Fetch fault; loader is ignored while in FAULT
        PC = 32'(4 * IW);
        cyc();
        PC = 32'h0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hEEEE_EEEE;
        @(negedge clk);
        chk("ffault_range", 32'(range_err), 32'd1);
        chk("ffault_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ffault_inst", Inst, 32'h0000_0013);
        cyc(); cyc();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("ffault_hold", 32'(cpu_reset), 32'd1);
        cyc();
        do_reset();
        mem_addr = 32'h10;
        @(negedge clk);
        chk("recov_range", 32'(range_err), 32'd0);
        chk("recov_ready", 32'(ld_ready), 32'd1);
        chk("recov_dmem", data_in, 32'h0102_0304);
        cyc();

        // Write-after-read store
        beat(32'h8, 32'hCAFE_F00D, 1'b1);
        cyc();
        @(negedge clk);
        chk("fault_ld_ignored", Inst, 32'h1111_1111);
        cyc();
        MemWE = 1'b1; mem_addr = 32'h10; data_out = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("war_old", data_in, 32'h0102_0304);
        cyc();
        MemWE = 1'b0;
        @(negedge clk);
        chk("war_new", data_in, 32'hDEAD_BEEF);
        chk("war_count", 32'(store_count), 32'd1);
        cyc();

        // Store fault
        MemWE = 1'b1; mem_addr = 32'h13; data_out = 32'h5555_5555;
        cyc();
        MemWE = 1'b0; mem_addr = 32'h10;
        @(negedge clk);
        chk("sfault_mis", 32'(misalign_err), 32'd1);
        chk("sfault_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("sfault_inst", Inst, 32'h0000_0013);
        chk("sfault_nowrite", data_in, 32'hDEAD_BEEF);
        cyc();

        // Reset during a store aborts it
        do_reset();
        beat(32'h8, 32'hCAFE_F00D, 1'b1);
        cyc();
        reset = 1'b1; MemWE = 1'b1; mem_addr = 32'h10; data_out = 32'h7777_7777;
        cyc();
        reset = 1'b0; MemWE = 1'b0;
        @(negedge clk);
        chk("rstst_nowrite", data_in, 32'hDEAD_BEEF);
        chk("rstst_count", 32'(store_count), 32'd0);
        cyc();

        // Coincident misalign + range store fault
        beat(32'h8, 32'hCAFE_F00D, 1'b1);
        cyc();
        MemWE = 1'b1; mem_addr = 32'(4 * DW + 2);
        cyc();
        MemWE = 1'b0; mem_addr = 32'h10;
        @(negedge clk);
        chk("both_flags", {30'd0, misalign_err, range_err}, 32'd3);
        cyc();

        // Counter saturation
        do_reset();
        beat(32'h8, 32'hCAFE_F00D, 1'b1);
        cyc();
        MemWE = 1'b1; mem_addr = 32'h20;
        for (int i = 0; i < 65534; i++) begin
            data_out = 32'(i);
            cyc();
        end
        MemWE = 1'b0;
        @(negedge clk);
        chk("sat_fffe", 32'(store_count), 32'h0000_FFFE);
        cyc();
        MemWE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_out = 32'hA000_0000 + 32'(i);
            cyc();
        end
        MemWE = 1'b0;
        @(negedge clk);
        chk("sat_ffff", 32'(store_count), 32'h0000_FFFF);
        chk("sat_last_data", data_in, 32'hA000_0002);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
